// File: rtl/cv32e41p_mp_fifo.sv
// cv32e41p_mp_fifo: multi-port in-order FIFO between fetch/OBI response and
// the aligner. Up to PUSH_W entries enter and up to POP_W entries leave per
// cycle. Status outputs depend on registered state only. Overflow and
// underflow are combinational request checks.
// Optional feature: define CV32E41P_MP_FIFO_HWM_EN to add the hwm_o
// high-water-mark output.
module cv32e41p_mp_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PUSH_W     = 2,
  parameter int unsigned POP_W      = 2,
  parameter int unsigned AF_THRESH  = DEPTH - 2,
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1),
  localparam int unsigned PCW       = $clog2(PUSH_W + 1),
  localparam int unsigned OCW       = $clog2(POP_W + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic                        flush_but_first_i,
  input  logic [PCW-1:0]              push_cnt_i,
  input  logic [PUSH_W*DATA_WIDTH-1:0] data_i,
  input  logic [OCW-1:0]              pop_cnt_i,
  output logic [POP_W*DATA_WIDTH-1:0] data_o,
  output logic [POP_W-1:0]            valid_o,
  output logic [CNT_W-1:0]            cnt_o,
  output logic [CNT_W-1:0]            free_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic                        almost_full_o,
  output logic                        overflow_o,
  output logic                        underflow_o
`ifdef CV32E41P_MP_FIFO_HWM_EN
  ,
  output logic [CNT_W-1:0]            hwm_o
`endif
);

  // Pointers only need to address DEPTH entries. One extra bit holds
  // pointer + offset before it wraps.
  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;

  localparam logic [PTR_W:0]   DEPTH_P = (PTR_W+1)'(DEPTH);
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);

  // Every offset added to a pointer is below DEPTH. One conditional
  // subtraction therefore wraps the sum for any DEPTH, including values that
  // are not a power of two.
  function automatic ptr_t wrap_idx(input logic [PTR_W:0] v);
    logic [PTR_W:0] r;
    r = (v >= DEPTH_P) ? (v - DEPTH_P) : v;
    return r[PTR_W-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] mem_q  [DEPTH];
  logic                  mem_we [DEPTH];
  logic [DATA_WIDTH-1:0] mem_wd [DEPTH];
  ptr_t                  rp_q, wp_q, rp_n, wp_n;
  ptr_t                  widx, ridx;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W:0]        cnt_n;
  logic [CNT_W:0]        cnt_ext, free_ext, push_ext, pop_ext;
  logic [CNT_W:0]        npush, npop;

  // Clamp the requests. Free space is taken from the registered count only,
  // so pops in the same cycle never make room for pushes.
  always_comb begin
    cnt_ext  = {1'b0, cnt_q};
    free_ext = DEPTH_C - cnt_ext;
    push_ext = (CNT_W+1)'(push_cnt_i);
    pop_ext  = (CNT_W+1)'(pop_cnt_i);
    npush    = (push_ext > free_ext) ? free_ext : push_ext;
    npop     = (pop_ext > cnt_ext) ? cnt_ext : pop_ext;
  end

  assign overflow_o    = (push_ext > free_ext);
  assign underflow_o   = (pop_ext > cnt_ext);
  assign cnt_o         = cnt_q;
  assign free_o        = free_ext[CNT_W-1:0];
  assign full_o        = (cnt_ext == DEPTH_C);
  assign empty_o       = (cnt_q == '0);
  assign almost_full_o = (cnt_q >= AF_C);

  // Map accepted push lanes onto per-entry write enables. A flush of either
  // kind discards the data offered in the same cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_we[i] = 1'b0;
      mem_wd[i] = '0;
    end
    widx = '0;
    if (!flush_i && !flush_but_first_i) begin
      for (int k = 0; k < PUSH_W; k++) begin
        if ((CNT_W+1)'(k) < npush) begin
          widx         = wrap_idx({1'b0, wp_q} + (PTR_W+1)'(k));
          mem_we[widx] = 1'b1;
          mem_wd[widx] = data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Present the oldest POP_W stored entries from the read pointer onward.
  always_comb begin
    data_o  = '0;
    valid_o = '0;
    ridx    = '0;
    for (int k = 0; k < POP_W; k++) begin
      ridx                              = wrap_idx({1'b0, rp_q} + (PTR_W+1)'(k));
      data_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[ridx];
      valid_o[k]                        = (CNT_W'(k) < cnt_q);
    end
  end

  // Select the next pointers and count. A full flush wins over a keep-head
  // flush, and a keep-head flush wins over normal push/pop traffic.
  always_comb begin
    rp_n  = rp_q;
    wp_n  = wp_q;
    cnt_n = cnt_ext;
    if (flush_i || (flush_but_first_i && (cnt_q == '0))) begin
      rp_n  = '0;
      wp_n  = '0;
      cnt_n = '0;
    end else if (flush_but_first_i) begin
      rp_n  = rp_q;
      wp_n  = wrap_idx({1'b0, rp_q} + (PTR_W+1)'(1));
      cnt_n = (CNT_W+1)'(1);
    end else begin
      rp_n  = wrap_idx({1'b0, rp_q} + (PTR_W+1)'(npop));
      wp_n  = wrap_idx({1'b0, wp_q} + (PTR_W+1)'(npush));
      cnt_n = cnt_ext + npush - npop;
    end
  end

  // Pointer and count registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rp_q  <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      rp_q  <= rp_n;
      wp_q  <= wp_n;
      cnt_q <= cnt_n[CNT_W-1:0];
    end
  end

  // Storage is cleared on reset so that data_o reads zero afterwards.
  // Only entries being written change.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_we[i]) mem_q[i] <= mem_wd[i];
      end
    end
  end

`ifdef CV32E41P_MP_FIFO_HWM_EN
  logic [CNT_W-1:0] hwm_q;

  // Track the largest registered count since reset. Flushes leave it alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hwm_q <= '0;
    end else if (cnt_q > hwm_q) begin
      hwm_q <= cnt_q;
    end
  end

  assign hwm_o = hwm_q;
`endif

endmodule

// File: tb/tb_cv32e41p_mp_fifo.sv
// tb_cv32e41p_mp_fifo: self-checking bench for cv32e41p_mp_fifo.
// It drives a default instance (DEPTH=8) and a DEPTH=5 instance that
// exercises wrap-around. A queue model of the stored entries acts as the
// scoreboard.
module tb_cv32e41p_mp_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush, fbf;
  logic [1:0]  push_cnt, pop_cnt;
  logic [63:0] din, dout;
  logic [1:0]  valid;
  logic [3:0]  cnt, free;
  logic        full, empty, afull, ovf, unf;
`ifdef CV32E41P_MP_FIFO_HWM_EN
  logic [3:0]  hwm;
  logic [2:0]  hwm5;
`endif

  logic [1:0]  p5, o5;
  logic [63:0] din5, dout5;
  logic [1:0]  v5;
  logic [2:0]  cnt5, free5;
  logic        full5, empty5, afull5, ovf5, unf5;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] model_q[$];
  logic        ov_seen, un_seen;

  cv32e41p_mp_fifo u_dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .flush_i           (flush),
    .flush_but_first_i (fbf),
    .push_cnt_i        (push_cnt),
    .data_i            (din),
    .pop_cnt_i         (pop_cnt),
    .data_o            (dout),
    .valid_o           (valid),
    .cnt_o             (cnt),
    .free_o            (free),
    .full_o            (full),
    .empty_o           (empty),
    .almost_full_o     (afull),
    .overflow_o        (ovf),
    .underflow_o       (unf)
`ifdef CV32E41P_MP_FIFO_HWM_EN
    ,
    .hwm_o             (hwm)
`endif
  );

  cv32e41p_mp_fifo #(.DEPTH(5), .AF_THRESH(3)) u_dut5 (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .flush_i           (1'b0),
    .flush_but_first_i (1'b0),
    .push_cnt_i        (p5),
    .data_i            (din5),
    .pop_cnt_i         (o5),
    .data_o            (dout5),
    .valid_o           (v5),
    .cnt_o             (cnt5),
    .free_o            (free5),
    .full_o            (full5),
    .empty_o           (empty5),
    .almost_full_o     (afull5),
    .overflow_o        (ovf5),
    .underflow_o       (unf5)
`ifdef CV32E41P_MP_FIFO_HWM_EN
    ,
    .hwm_o             (hwm5)
`endif
  );

  // Drive one cycle on the DEPTH=8 instance, starting at a negedge. The
  // combinational flags are captured, the queue model is updated and the
  // task returns at the following negedge.
  task automatic step(input int pc, input logic [31:0] a, input logic [31:0] b,
                      input int oc, input logic fl, input logic ff);
    int          sz, np, no;
    logic [31:0] h;
    push_cnt = 2'(pc);
    pop_cnt  = 2'(oc);
    din      = {b, a};
    flush    = fl;
    fbf      = ff;
    #1;
    ov_seen = ovf;
    un_seen = unf;
    sz = model_q.size();
    if (fl || (ff && sz == 0)) begin
      model_q.delete();
    end else if (ff) begin
      h = model_q[0];
      model_q.delete();
      model_q.push_back(h);
    end else begin
      np = (pc > 8 - sz) ? 8 - sz : pc;
      no = (oc > sz) ? sz : oc;
      for (int i = 0; i < no; i++) void'(model_q.pop_front());
      if (np > 0) model_q.push_back(a);
      if (np > 1) model_q.push_back(b);
    end
    @(posedge clk);
    @(negedge clk);
    push_cnt = '0;
    pop_cnt  = '0;
    flush    = 1'b0;
    fbf      = 1'b0;
  endtask

  // Advance the DEPTH=5 instance by one cycle, from negedge to negedge.
  task automatic tick5();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; fbf = 1'b0; push_cnt = '0; pop_cnt = '0; din = '0;
    p5 = '0; o5 = '0; din5 = '0;
    #12;
    n_total++; if (cnt !== 4'd0) $display("[TB] FAIL reset_cnt got %0d want 0", cnt); else n_pass++;
    n_total++; if (free !== 4'd8) $display("[TB] FAIL reset_free got %0d want 8", free); else n_pass++;
    n_total++; if ({empty, full, afull} !== 3'b100) $display("[TB] FAIL reset_flags got %b want 100", {empty, full, afull}); else n_pass++;
    n_total++; if (valid !== 2'b00) $display("[TB] FAIL reset_valid got %b want 00", valid); else n_pass++;
    n_total++; if (dout !== 64'd0) $display("[TB] FAIL reset_data got %h want 0", dout); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_q.delete();
  endtask

  task automatic test_wrap5();
    p5 = 2; din5 = {32'hB, 32'hA}; tick5();
    p5 = 2; din5 = {32'hD, 32'hC}; tick5();
    p5 = 0; o5 = 2; tick5();
    o5 = 1; tick5();
    o5 = 0; p5 = 2; din5 = {32'hF, 32'hE}; tick5();
    p5 = 1; din5 = {32'h0, 32'h7}; tick5();
    p5 = 0;
    n_total++; if (cnt5 !== 3'd4) $display("[TB] FAIL wrap_cnt got %0d want 4", cnt5); else n_pass++;
    n_total++; if (dout5 !== {32'hE, 32'hD}) $display("[TB] FAIL wrap_lanes got %h want %h", dout5, {32'hE, 32'hD}); else n_pass++;
    n_total++; if ({free5, full5, afull5, empty5} !== {3'd1, 3'b010}) $display("[TB] FAIL wrap_status got %b want 001010", {free5, full5, afull5, empty5}); else n_pass++;
    o5 = 2; tick5();
    o5 = 0;
    n_total++; if (dout5 !== {32'h7, 32'hF} || v5 !== 2'b11 || cnt5 !== 3'd2) $display("[TB] FAIL wrap_after_pop got %h/%b/%0d want %h/11/2", dout5, v5, cnt5, {32'h7, 32'hF}); else n_pass++;
    o5 = 2; tick5();
    o5 = 0;
    n_total++; if (empty5 !== 1'b1) $display("[TB] FAIL wrap_drain got %b want 1", empty5); else n_pass++;
  endtask

  task automatic test_basic();
    step(2, 32'hAAAA_0001, 32'hBBBB_0002, 0, 1'b0, 1'b0);
    n_total++; if (cnt !== 4'd2) $display("[TB] FAIL basic_cnt got %0d want 2", cnt); else n_pass++;
    n_total++; if (valid !== 2'b11) $display("[TB] FAIL basic_valid got %b want 11", valid); else n_pass++;
    n_total++; if (dout !== {32'hBBBB_0002, 32'hAAAA_0001}) $display("[TB] FAIL basic_data got %h want bbbb0002aaaa0001", dout); else n_pass++;
    n_total++; if (free !== 4'd6) $display("[TB] FAIL basic_free got %0d want 6", free); else n_pass++;
  endtask

  task automatic test_af_hwm();
    step(2, 32'h11, 32'h12, 0, 1'b0, 1'b0);
    n_total++; if (afull !== 1'b0) $display("[TB] FAIL af_at4 got %b want 0", afull); else n_pass++;
    step(2, 32'h13, 32'h14, 0, 1'b0, 1'b0);
    n_total++; if (afull !== 1'b1 || cnt !== 4'd6) $display("[TB] FAIL af_at6 got %b/%0d want 1/6", afull, cnt); else n_pass++;
    step(0, 32'h0, 32'h0, 0, 1'b1, 1'b0);
    n_total++; if (afull !== 1'b0 || empty !== 1'b1) $display("[TB] FAIL af_flush got %b/%b want 0/1", afull, empty); else n_pass++;
    step(0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
`ifdef CV32E41P_MP_FIFO_HWM_EN
    n_total++; if (hwm !== 4'd6) $display("[TB] FAIL hwm_after_flush got %0d want 6", hwm); else n_pass++;
`endif
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) step(2, 32'hF000_0000 + 32'(2*i), 32'hF000_0001 + 32'(2*i), 0, 1'b0, 1'b0);
    n_total++; if (full !== 1'b1 || cnt !== 4'd8 || free !== 4'd0) $display("[TB] FAIL full_state got %b/%0d/%0d want 1/8/0", full, cnt, free); else n_pass++;
    step(2, 32'hDEAD_0001, 32'hDEAD_0002, 1, 1'b0, 1'b0);
    n_total++; if (ov_seen !== 1'b1) $display("[TB] FAIL full_overflow got %b want 1", ov_seen); else n_pass++;
    n_total++; if (cnt !== 4'd7 || full !== 1'b0) $display("[TB] FAIL full_after got %0d/%b want 7/0", cnt, full); else n_pass++;
    n_total++; if (dout[31:0] !== 32'hF000_0001) $display("[TB] FAIL full_head got %h want f0000001", dout[31:0]); else n_pass++;
  endtask

  task automatic test_underflow();
    for (int i = 0; i < 3; i++) step(0, 32'h0, 32'h0, 2, 1'b0, 1'b0);
    n_total++; if (cnt !== 4'd1 || valid !== 2'b01 || dout[31:0] !== 32'hF000_0007) $display("[TB] FAIL uf_pre got %0d/%b/%h want 1/01/f0000007", cnt, valid, dout[31:0]); else n_pass++;
    step(0, 32'h0, 32'h0, 2, 1'b0, 1'b0);
    n_total++; if (un_seen !== 1'b1) $display("[TB] FAIL uf_flag got %b want 1", un_seen); else n_pass++;
    n_total++; if (cnt !== 4'd0 || empty !== 1'b1 || valid !== 2'b00) $display("[TB] FAIL uf_after got %0d/%b/%b want 0/1/00", cnt, empty, valid); else n_pass++;
  endtask

  task automatic test_flush_but_first();
    step(2, 32'hC0, 32'hC1, 0, 1'b0, 1'b0);
    step(2, 32'hC2, 32'hC3, 0, 1'b0, 1'b0);
    step(1, 32'hC4, 32'h0, 0, 1'b0, 1'b0);
    step(2, 32'hEE01, 32'hEE02, 0, 1'b0, 1'b1);
    n_total++; if (cnt !== 4'd1 || valid !== 2'b01 || dout[31:0] !== 32'hC0) $display("[TB] FAIL fbf_keep got %0d/%b/%h want 1/01/c0", cnt, valid, dout[31:0]); else n_pass++;
    step(1, 32'h77, 32'h0, 0, 1'b0, 1'b0);
    n_total++; if (cnt !== 4'd2 || dout !== {32'h77, 32'hC0}) $display("[TB] FAIL fbf_next got %0d/%h want 2/00000077000000c0", cnt, dout); else n_pass++;
    step(0, 32'h0, 32'h0, 2, 1'b0, 1'b0);
    step(2, 32'hEE03, 32'hEE04, 0, 1'b0, 1'b1);
    n_total++; if (cnt !== 4'd0 || empty !== 1'b1) $display("[TB] FAIL fbf_empty got %0d/%b want 0/1", cnt, empty); else n_pass++;
  endtask

  task automatic test_async_reset();
    step(2, 32'h51, 32'h52, 0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (cnt !== 4'd0 || empty !== 1'b1 || valid !== 2'b00) $display("[TB] FAIL areset_clear got %0d/%b/%b want 0/1/00", cnt, empty, valid); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_q.delete();
    step(2, 32'h61, 32'h62, 0, 1'b0, 1'b0);
    n_total++; if (cnt !== 4'd2 || dout !== {32'h62, 32'h61}) $display("[TB] FAIL areset_first_push got %0d/%h want 2/0000006200000061", cnt, dout); else n_pass++;
    step(0, 32'h0, 32'h0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int          pc, oc, sz;
    logic        fl, ff, exp_ov, exp_un;
    logic [1:0]  ev;
    logic [31:0] got;
    for (int cyc = 0; cyc < 400; cyc++) begin
      pc = $urandom_range(0, 2);
      oc = (cyc < 200) ? $urandom_range(0, 1) : $urandom_range(0, 2);
      fl = ($urandom_range(0, 63) == 0);
      ff = ($urandom_range(0, 47) == 0);
      sz = model_q.size();
      exp_ov = (pc > 8 - sz);
      exp_un = (oc > sz);
      step(pc, $urandom, $urandom, oc, fl, ff);
      n_total++; if ({ov_seen, un_seen} !== {exp_ov, exp_un}) $display("[TB] FAIL rnd_flags cyc %0d got %b want %b", cyc, {ov_seen, un_seen}, {exp_ov, exp_un}); else n_pass++;
      sz = model_q.size();
      n_total++; if (cnt !== 4'(sz) || free !== 4'(8 - sz) || full !== (sz == 8) || empty !== (sz == 0)) $display("[TB] FAIL rnd_status cyc %0d got cnt %0d free %0d want cnt %0d", cyc, cnt, free, sz); else n_pass++;
      ev = {sz > 1, sz > 0};
      n_total++; if (valid !== ev) $display("[TB] FAIL rnd_valid cyc %0d got %b want %b", cyc, valid, ev); else n_pass++;
      for (int k = 0; k < 2; k++) begin
        if (sz > k) begin
          got = dout[k*32 +: 32];
          n_total++; if (got !== model_q[k]) $display("[TB] FAIL rnd_lane%0d cyc %0d got %h want %h", k, cyc, got, model_q[k]); else n_pass++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap5();
    test_basic();
    test_af_hwm();
    test_full_push_pop();
    test_underflow();
    test_flush_but_first();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
